serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl_if.sv | 24 ++
 rtl/serial_sub_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - request/result bundle for the bit-serial subtractor
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bIn;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bOut;

    modport master (
        output start, a, b, bIn,
        input  ready, busy, done, diff, bOut
    );

    modport slave (
        input  start, a, b, bIn,
        output ready, busy, done, diff, bOut
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial WIDTH-bit subtractor built around one full-subtractor cell
module full_subtractor (
    input  logic [1:0] ip,
    input  logic       bIn,
    output logic       diff,
    output logic       bOut
);
    // ip[1] is the minuend bit; it selects which borrow equation applies
    assign diff = ip[1] ^ ip[0] ^ bIn;
    assign bOut = ip[1] ? (ip[0] & bIn) : (ip[0] | bIn);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] d_sh_shift;

    full_subtractor u_cell (
        .ip   ({a_sh_q[0], b_sh_q[0]}),
        .bIn  (brw_q),
        .diff (cell_diff),
        .bOut (cell_bout)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts
    always_comb begin
        d_sh_shift            = d_sh_q >> 1;
        d_sh_shift[WIDTH-1]   = cell_diff;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    brw_d   = bus.bIn;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_sh_d = d_sh_shift;
                brw_d  = cell_bout;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = d_sh_shift;
                    bout_d  = cell_bout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.diff  = diff_q;
    assign bus.bOut  = bout_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl at WIDTH 8, 4 and 1
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(4)) if4 ();
    serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_sub_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int total = 0;
    int bad   = 0;
    int starts8 = 0, dones8 = 0;
    int starts4 = 0, dones4 = 0;
    int starts1 = 0, dones1 = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [1:0] q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a done pulse is seen
    always @(negedge clk) begin
        if (rst_n && if8.done) begin
            dones8++;
            if (q8.size() == 0) chk("dut8_unexpected_done", 1, 0);
            else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("dut8_diff", if8.diff, e[8:1]);
                chk("dut8_bout", if8.bOut, e[0]);
            end
        end
        if (rst_n && if4.done) begin
            dones4++;
            if (q4.size() == 0) chk("dut4_unexpected_done", 1, 0);
            else begin
                logic [4:0] e;
                e = q4.pop_front();
                chk("dut4_diff", if4.diff, e[4:1]);
                chk("dut4_bout", if4.bOut, e[0]);
            end
        end
        if (rst_n && if1.done) begin
            dones1++;
            if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else begin
                logic [1:0] e;
                e = q1.pop_front();
                chk("dut1_diff", if1.diff, e[1]);
                chk("dut1_bout", if1.bOut, e[0]);
            end
        end
    end

    task automatic wait_ready8();
        int n = 0;
        while (!if8.ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("dut8_wait_ready", if8.ready, 1);
    endtask

    task automatic wait_ready4();
        int n = 0;
        while (!if4.ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("dut4_wait_ready", if4.ready, 1);
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (!if1.ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("dut1_wait_ready", if1.ready, 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb);
        wait_ready8();
        if8.a = a; if8.b = b; if8.bIn = bi; if8.start = 1'b1;
        q8.push_back({ed, eb});
        starts8++;
        @(posedge clk); #1;
        if8.start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((dones8 != starts8 || dones4 != starts4 || dones1 != starts1) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_done8_count"}, dones8, starts8);
        chk({nm, "_done4_count"}, dones4, starts4);
        chk({nm, "_done1_count"}, dones1, starts1);
    endtask

    initial begin
        if8.start = 0; if8.a = 0; if8.b = 0; if8.bIn = 0;
        if4.start = 0; if4.a = 0; if4.b = 0; if4.bIn = 0;
        if1.start = 0; if1.a = 0; if1.b = 0; if1.bIn = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", if8.ready, 1);
        chk("reset_busy",  if8.busy,  0);
        chk("reset_done",  if8.done,  0);
        chk("reset_diff",  if8.diff,  0);
        chk("reset_bout",  if8.bOut,  0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic op with cycle-by-cycle latency checks
        op8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk("lat_busy", if8.busy, 1);
            @(posedge clk); #1;
        end
        chk("lat_done", if8.done, 1);
        chk("lat_busy_off", if8.busy, 0);
        @(posedge clk); #1;
        chk("lat_ready_after", if8.ready, 1);
        chk("lat_done_pulse", if8.done, 0);

        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        drain("directed");

        // start held high, operands changing during RUN/DONE
        wait_ready8();
        if8.a = 8'h10; if8.b = 8'h01; if8.bIn = 0; if8.start = 1'b1;
        q8.push_back({8'h0F, 1'b0});
        starts8++;
        @(posedge clk); #1;
        if8.a = 8'hAA; if8.b = 8'h55;
        begin
            int n = 0;
            while (!if8.done && n < 20) begin @(posedge clk); #1; n++; end
            chk("hold_done_seen", if8.done, 1);
        end
        q8.push_back({8'h55, 1'b0});
        starts8++;
        @(posedge clk); #1;
        chk("hold_ready_after_done", if8.ready, 1);
        @(posedge clk); #1;
        chk("hold_second_accepted", if8.busy, 1);
        if8.start = 1'b0;
        drain("hold");

        // Asynchronous reset at cnt=4, mid-cycle
        wait_ready8();
        if8.a = 8'h5A; if8.b = 8'h21; if8.bIn = 0; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_ready", if8.ready, 1);
        chk("async_busy",  if8.busy,  0);
        chk("async_done",  if8.done,  0);
        chk("async_diff",  if8.diff,  0);
        chk("async_bout",  if8.bOut,  0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("async_no_done", dones8, starts8);
        op8(8'h09, 8'h03, 1'b0, 8'h06, 1'b0);
        drain("after_reset");

        // Exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    logic [4:0] r;
                    r = 5'(a) - 5'(b) - 5'(bi);
                    wait_ready4();
                    if4.a = 4'(a); if4.b = 4'(b); if4.bIn = bi[0]; if4.start = 1'b1;
                    q4.push_back({r[3:0], (a < b + bi) ? 1'b1 : 1'b0});
                    starts4++;
                    @(posedge clk); #1;
                    if4.start = 1'b0;
                end
        drain("sweep4");

        // Exhaustive WIDTH=1 sweep
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    logic [1:0] r;
                    r = 2'(a) - 2'(b) - 2'(bi);
                    wait_ready1();
                    if1.a = a[0]; if1.b = b[0]; if1.bIn = bi[0]; if1.start = 1'b1;
                    q1.push_back({r[0], (a < b + bi) ? 1'b1 : 1'b0});
                    starts1++;
                    @(posedge clk); #1;
                    if1.start = 1'b0;
                end
        drain("sweep1");

        chk("q8_empty", q8.size(), 0);
        chk("q4_empty", q4.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
